uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-level command parser between the UART receiver and the alarm-clock core. It consumes the one-cycle `rx_data`/`rx_data_rdy` byte stream and decodes the load-time command (`l`), the load-alarm command (`a`) and the alarm-enable toggle (`@`). It range-checks the four BCD digits and issues one-cycle load strobes with the digits held stable for the time and alarm registers. Every received byte is echoed on the tx side one cycle later.

## Interface
- `CR`, default 8'h0D: command terminator byte.
- `clk12m`  in  1  system clock, 12 MHz.
- `rst_n`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk12m`.
- `rx_data`  in  8  received ASCII byte; valid only when `rx_data_rdy`=1.
- `rx_data_rdy`  in  1  byte-valid qualifier; each high cycle is one byte.
- `ld_time`  out  1  one-cycle strobe: load the time register from `ld_mtens..ld_sones`.
- `ld_alarm`  out  1  one-cycle strobe: load the alarm register from `ld_mtens..ld_sones`.
- `ld_mtens`, `ld_mones`, `ld_stens`, `ld_sones`  out  4 each  BCD digits of the last accepted command.
- `alarm_en`  out  1  alarm-enable level, toggled by `@`.
- `cmd_err`  out  1  one-cycle strobe: command rejected.
- `busy`  out  1  1 while a command is being collected (state ≠ IDLE).
- `tx_data`  out  8  echo of the received byte.
- `tx_data_rdy`  out  1  echo qualifier.

## Operation
- States: IDLE, COLLECT, WAIT_CR.
- Registers:
  - `kind`: 0 = time, 1 = alarm.
  - `cnt`: 3-bit digit count, 0..4.
  - Four 4-bit staging digits.
- The parser acts only on cycles with `rx_data_rdy`=1. All other cycles hold state.
- IDLE:
  - `l` or `L` → COLLECT with kind=0, cnt=0.
  - `a` or `A` → COLLECT with kind=1, cnt=0.
  - `@` → toggle `alarm_en`.
  - Any other byte, including digits and CR, is ignored with no error.
- COLLECT:
  - Digit `0`-`9` → stage[cnt] = byte − 8'h30, then cnt+1. When cnt reaches 4, go to WAIT_CR.
  - `l/L/a/A` → pulse `cmd_err`, discard the staged digits, restart COLLECT with the new kind and cnt=0.
  - CR or any other byte → pulse `cmd_err`, go to IDLE.
- WAIT_CR:
  - CR → check the range: staged Mtens ≤ 5 and Stens ≤ 5.
    - Pass: copy the staging digits to `ld_*`, pulse `ld_time` (kind=0) or `ld_alarm` (kind=1), go to IDLE.
    - Fail: pulse `cmd_err`, leave `ld_*` unchanged, go to IDLE.
  - `l/L/a/A` → pulse `cmd_err`, restart as in COLLECT.
  - Any other byte, including a 5th digit → pulse `cmd_err`, go to IDLE.
- `@` outside IDLE is an ordinary invalid byte: `cmd_err`, no toggle.
- Digit order on the wire is Mtens, Mones, Stens, Sones. Example: `l5910` = 59:10.
- Echo: every byte with `rx_data_rdy`=1 is copied to `tx_data` with `tx_data_rdy`=1, regardless of state or validity.
- At most one of `ld_time`, `ld_alarm`, `cmd_err` is high in any cycle.

## Timing
- Reset values (state after `rst_n`=0 at an edge):
  - State IDLE, cnt 0, staging digits 0.
  - `ld_time`, `ld_alarm`, `cmd_err`, `alarm_en`, `busy`, `tx_data_rdy` = 0.
  - `ld_*` digits = 0, `tx_data` = 0.
- Reset mid-command aborts the command with no strobe and no error. Reset has priority over a byte in the same cycle.
- All outputs are registered.
- Latency: byte sampled at edge N → strobe, toggle, error, echo and state change are visible after edge N+1, i.e. one cycle. Strobes are exactly one cycle wide.
- `ld_*` digits change only in the cycle `ld_time`/`ld_alarm` asserts, and hold until the next successful load.
- Back-to-back bytes on consecutive cycles are fully supported. No backpressure; no byte is ever dropped.
- `busy` goes high one cycle after the command letter and low one cycle after the terminating or erroring byte.

## Test plan
- `l`,`5`,`9`,`1`,`0`,CR with one idle cycle between bytes → `ld_time`=1 for one cycle, one clock after CR; `ld_mtens/mones/stens/sones`=5/9/1/0; `ld_alarm` and `cmd_err` stay 0; `tx_data` echoes all 6 bytes.
- `a5959`,CR then `@`, and later a second `@`, all bytes on consecutive cycles → `ld_alarm` pulse with digits 5/9/5/9; `alarm_en` 0→1 one cycle after the first `@`, 1→0 after the second.
- `l6000`,CR → `cmd_err` pulse one cycle after CR; no `ld_time`; `ld_*` keep their previous values. Repeat with `l0560`,CR → same result.
- `l59`,CR → `cmd_err` after CR. `l59100` → `cmd_err` on the 5th digit, parser back in IDLE, a following CR is ignored.
- `l12a3456`,CR → `cmd_err` on the `a`, then an `ld_alarm` pulse with 3/4/5/6; `ld_time` never asserts.
- `l59`, then `rst_n`=0 for one cycle, then `10`,CR → no strobes and no `cmd_err`; `busy`=0 after reset; `alarm_en`=0; the digits are ignored in IDLE.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream bundle between the UART and the command parser.
// The receive side is driven by the UART; the transmit side echoes bytes back.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_data_rdy;
  logic [7:0] tx_data;
  logic       tx_data_rdy;

  modport master (
    output rx_data, rx_data_rdy,
    input  tx_data, tx_data_rdy
  );

  modport slave (
    input  rx_data, rx_data_rdy,
    output tx_data, tx_data_rdy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes l/a time/alarm load commands and the @ alarm toggle from a UART byte stream,
// range-checks the four BCD digits, and echoes every received byte one cycle later.
module uart_cmd_parser #(
  parameter logic [7:0] CR = 8'h0D
) (
  input  logic                      clk12m,
  input  logic                      rst_n,
  uart_cmd_parser_if.slave          bus,
  output logic                      ld_time,
  output logic                      ld_alarm,
  output logic [3:0]                ld_mtens,
  output logic [3:0]                ld_mones,
  output logic [3:0]                ld_stens,
  output logic [3:0]                ld_sones,
  output logic                      alarm_en,
  output logic                      cmd_err,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_CR} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_kind, w_kind_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_stage [4];
  logic [3:0] w_stage_nxt [4];
  logic [3:0] r_ld [4];
  logic [3:0] w_ld_nxt [4];
  logic       r_ld_time, w_ld_time_nxt;
  logic       r_ld_alarm, w_ld_alarm_nxt;
  logic       r_cmd_err, w_cmd_err_nxt;
  logic       r_alarm_en, w_alarm_en_nxt;
  logic       r_busy;
  logic [7:0] r_tx_data;
  logic       r_tx_data_rdy;

  logic       w_is_l, w_is_a, w_is_letter, w_is_digit;

  assign w_is_l      = (bus.rx_data == 8'h6C) || (bus.rx_data == 8'h4C);
  assign w_is_a      = (bus.rx_data == 8'h61) || (bus.rx_data == 8'h41);
  assign w_is_letter = w_is_l || w_is_a;
  assign w_is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);

  always_comb begin
    w_state_nxt    = r_state;
    w_kind_nxt     = r_kind;
    w_cnt_nxt      = r_cnt;
    w_stage_nxt    = r_stage;
    w_ld_nxt       = r_ld;
    w_ld_time_nxt  = 1'b0;
    w_ld_alarm_nxt = 1'b0;
    w_cmd_err_nxt  = 1'b0;
    w_alarm_en_nxt = r_alarm_en;

    if (bus.rx_data_rdy) begin
      unique case (r_state)
        IDLE: begin
          if (w_is_letter) begin
            w_state_nxt = COLLECT;
            w_kind_nxt  = w_is_a;
            w_cnt_nxt   = '0;
          end else if (bus.rx_data == 8'h40) begin
            w_alarm_en_nxt = ~r_alarm_en;
          end
        end

        COLLECT: begin
          if (w_is_letter) begin
            w_cmd_err_nxt = 1'b1;
            w_state_nxt   = COLLECT;
            w_kind_nxt    = w_is_a;
            w_cnt_nxt     = '0;
            w_stage_nxt   = '{default: '0};
          end else if (w_is_digit) begin
            // ASCII '0'..'9' carry their BCD value in the low nibble
            w_stage_nxt[r_cnt[1:0]] = bus.rx_data[3:0];
            w_cnt_nxt               = r_cnt + 3'd1;
            if (r_cnt == 3'd3)
              w_state_nxt = WAIT_CR;
          end else begin
            w_cmd_err_nxt = 1'b1;
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
          end
        end

        WAIT_CR: begin
          if (bus.rx_data == CR) begin
            if ((r_stage[0] <= 4'd5) && (r_stage[2] <= 4'd5)) begin
              w_ld_nxt       = r_stage;
              w_ld_time_nxt  = ~r_kind;
              w_ld_alarm_nxt = r_kind;
            end else begin
              w_cmd_err_nxt = 1'b1;
            end
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_is_letter) begin
            w_cmd_err_nxt = 1'b1;
            w_state_nxt   = COLLECT;
            w_kind_nxt    = w_is_a;
            w_cnt_nxt     = '0;
            w_stage_nxt   = '{default: '0};
          end else begin
            w_cmd_err_nxt = 1'b1;
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk12m) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_kind        <= 1'b0;
      r_cnt         <= '0;
      r_stage       <= '{default: '0};
      r_ld          <= '{default: '0};
      r_ld_time     <= 1'b0;
      r_ld_alarm    <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_alarm_en    <= 1'b0;
      r_busy        <= 1'b0;
      r_tx_data     <= '0;
      r_tx_data_rdy <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_kind        <= w_kind_nxt;
      r_cnt         <= w_cnt_nxt;
      r_stage       <= w_stage_nxt;
      r_ld          <= w_ld_nxt;
      r_ld_time     <= w_ld_time_nxt;
      r_ld_alarm    <= w_ld_alarm_nxt;
      r_cmd_err     <= w_cmd_err_nxt;
      r_alarm_en    <= w_alarm_en_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_tx_data_rdy <= bus.rx_data_rdy;
      if (bus.rx_data_rdy)
        r_tx_data <= bus.rx_data;
    end
  end

  assign ld_time         = r_ld_time;
  assign ld_alarm        = r_ld_alarm;
  assign cmd_err         = r_cmd_err;
  assign alarm_en        = r_alarm_en;
  assign busy            = r_busy;
  assign ld_mtens        = r_ld[0];
  assign ld_mones        = r_ld[1];
  assign ld_stens        = r_ld[2];
  assign ld_sones        = r_ld[3];
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_data_rdy = r_tx_data_rdy;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised scoreboard bench for uart_cmd_parser: a command-level reference model
// predicts each echoed byte's companion outputs; a monitor pops and compares them.
module tb_uart_cmd_parser;
  localparam logic [7:0] CR = 8'h0D;

  logic       clk12m = 1'b0;
  logic       rst_n;
  logic       ld_time, ld_alarm, alarm_en, cmd_err, busy;
  logic [3:0] ld_mtens, ld_mones, ld_stens, ld_sones;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.CR(CR)) dut (
    .clk12m   (clk12m),
    .rst_n    (rst_n),
    .bus      (bus),
    .ld_time  (ld_time),
    .ld_alarm (ld_alarm),
    .ld_mtens (ld_mtens),
    .ld_mones (ld_mones),
    .ld_stens (ld_stens),
    .ld_sones (ld_sones),
    .alarm_en (alarm_en),
    .cmd_err  (cmd_err),
    .busy     (busy)
  );

  always #5 clk12m = ~clk12m;

  typedef struct {
    logic [7:0]  tx;
    logic        lt, la, err, aen, bsy;
    logic [15:0] ld;
  } exp_t;

  exp_t expq [$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;

  // reference model: command-level view (pending command + list of digits so far)
  bit          m_active = 1'b0;
  bit          m_kind   = 1'b0;
  bit          m_aen    = 1'b0;
  logic [15:0] m_ld     = '0;
  int          dq [$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic bit is_letter(logic [7:0] b);
    return (b == "l") || (b == "L") || (b == "a") || (b == "A");
  endfunction

  task automatic model(input logic [7:0] b);
    exp_t e;
    e.tx = b; e.lt = 0; e.la = 0; e.err = 0;
    if (!m_active) begin
      if (is_letter(b)) begin
        m_active = 1; m_kind = (b == "a") || (b == "A"); dq.delete();
      end else if (b == "@") begin
        m_aen = !m_aen;
      end
    end else if (is_letter(b)) begin
      e.err = 1; m_kind = (b == "a") || (b == "A"); dq.delete();
    end else if (dq.size() < 4 && b >= "0" && b <= "9") begin
      dq.push_back(int'(b) - 48);
    end else if (dq.size() == 4 && b == CR) begin
      if (dq[0] <= 5 && dq[2] <= 5) begin
        m_ld = {4'(dq[0]), 4'(dq[1]), 4'(dq[2]), 4'(dq[3])};
        if (m_kind) e.la = 1; else e.lt = 1;
      end else begin
        e.err = 1;
      end
      m_active = 0;
    end else begin
      e.err = 1; m_active = 0;
    end
    e.aen = m_aen; e.bsy = m_active; e.ld = m_ld;
    expq.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk12m);
    bus.rx_data = b; bus.rx_data_rdy = 1'b1;
    model(b);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk12m);
      bus.rx_data_rdy = 1'b0;
      bus.rx_data = 8'($urandom);
    end
  endtask

  task automatic send_str(input string s, input int unsigned gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (gap != 0) idle(gap);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_ld_time", ld_time, 0);
    chk("rst_ld_alarm", ld_alarm, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_alarm_en", alarm_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_rdy", bus.tx_data_rdy, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_ld_digits", {ld_mtens, ld_mones, ld_stens, ld_sones}, 0);
  endtask

  // a byte is presented in the reset cycle to show reset wins over it
  task automatic do_reset();
    idle(2);
    @(negedge clk12m);
    rst_n = 1'b0; bus.rx_data = "@"; bus.rx_data_rdy = 1'b1;
    m_active = 0; m_aen = 0; m_ld = '0; dq.delete();
    @(posedge clk12m);
    #1 check_reset_state();
    @(negedge clk12m);
    rst_n = 1'b1; bus.rx_data_rdy = 1'b0;
  endtask

  function automatic logic [7:0] rnd_letter();
    case ($urandom_range(0, 3))
      0: return "l";
      1: return "L";
      2: return "a";
      default: return "A";
    endcase
  endfunction

  task automatic rnd_bytes(input int unsigned n_digits);
    for (int unsigned i = 0; i < n_digits; i++) begin
      send(8'h30 + 8'($urandom_range(0, 9)));
      idle($urandom_range(0, 1));
    end
  endtask

  always @(posedge clk12m) begin
    #1;
    if (mon_on) begin
      if (bus.tx_data_rdy) begin
        if (expq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_echo: actual tx %0h required none", bus.tx_data);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("tx_data", bus.tx_data, e.tx);
          chk("ld_time", ld_time, e.lt);
          chk("ld_alarm", ld_alarm, e.la);
          chk("cmd_err", cmd_err, e.err);
          chk("alarm_en", alarm_en, e.aen);
          chk("busy", busy, e.bsy);
          chk("ld_digits", {ld_mtens, ld_mones, ld_stens, ld_sones}, e.ld);
        end
      end else begin
        chk("quiet_strobes", {ld_time, ld_alarm, cmd_err}, 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.rx_data = '0;
    bus.rx_data_rdy = 1'b0;
    repeat (2) @(posedge clk12m);
    #1 check_reset_state();
    mon_on = 1'b1;
    @(negedge clk12m);
    rst_n = 1'b1;

    // directed cases
    send_str("l5910", 1); send(CR); idle(2);
    send_str("a5959", 0); send(CR); send("@"); idle(3); send("@"); idle(2);
    send_str("l6000", 0); send(CR); idle(1);
    send_str("l0560", 0); send(CR); idle(1);
    send_str("l59", 0); send(CR); idle(1);
    send_str("l59100", 0); send(CR); idle(1);
    send_str("l12a3456", 0); send(CR); idle(1);
    send_str("l59", 0);
    do_reset();
    send_str("10", 0); send(CR); idle(2);

    // randomised command streams
    for (int unsigned k = 0; k < 200; k++) begin
      case ($urandom_range(0, 6))
        0, 1: begin
          send(rnd_letter()); idle($urandom_range(0, 1));
          send(8'h30 + 8'($urandom_range(0, 6)));
          send(8'h30 + 8'($urandom_range(0, 9)));
          send(8'h30 + 8'($urandom_range(0, 6)));
          send(8'h30 + 8'($urandom_range(0, 9)));
          idle($urandom_range(0, 1)); send(CR);
        end
        2: begin send(rnd_letter()); rnd_bytes($urandom_range(0, 5)); send(CR); end
        3: send("@");
        4: send(8'($urandom));
        5: begin send(rnd_letter()); rnd_bytes(2); send(rnd_letter()); rnd_bytes(4); send(CR); end
        default: if ($urandom_range(0, 9) == 0) do_reset(); else send(CR);
      endcase
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
